wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master Wishbone arbiter with a shared slave port.
//   m0 = CPU data port, m1 = DMA/debug port. Grants are held for as long as
//   the owning master keeps cyc high. Ties in IDLE alternate between the
//   masters, and a slave that stalls a strobe for TIMEOUT_CYCLES cycles gets
//   the transfer terminated with a bus error.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   mN_cyc/stb/adr/we/dat_o/sel   master N request side (N = 0, 1)
//   mN_dat_i/ack/err    master N response side (zero unless N owns the bus)
//   s_cyc/stb/adr/we/dat_o/sel    shared downstream request side
//   s_dat_i/ack/err     downstream response side
//   grant               one-hot owner (bit0 = m0, bit1 = m1), 00 when idle
//   timeout_o           one-cycle pulse on a forced timeout
//
// state   | meaning
// IDLE    | no owner, arbitrating among raised cyc lines
// BUSY_M0 | m0 owns the slave port
// BUSY_M1 | m1 owns the slave port
module wb_arbiter #(
   parameter int WISHBONE_ADDR_WIDTH = 32,
   parameter int WISHBONE_BUS_WIDTH  = 32,
   parameter int TIMEOUT_CYCLES      = 255
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            m0_cyc,
   input  logic                            m0_stb,
   input  logic [WISHBONE_ADDR_WIDTH-1:0]  m0_adr,
   input  logic                            m0_we,
   input  logic [WISHBONE_BUS_WIDTH-1:0]   m0_dat_o,
   input  logic [WISHBONE_BUS_WIDTH/8-1:0] m0_sel,
   output logic [WISHBONE_BUS_WIDTH-1:0]   m0_dat_i,
   output logic                            m0_ack,
   output logic                            m0_err,
   input  logic                            m1_cyc,
   input  logic                            m1_stb,
   input  logic [WISHBONE_ADDR_WIDTH-1:0]  m1_adr,
   input  logic                            m1_we,
   input  logic [WISHBONE_BUS_WIDTH-1:0]   m1_dat_o,
   input  logic [WISHBONE_BUS_WIDTH/8-1:0] m1_sel,
   output logic [WISHBONE_BUS_WIDTH-1:0]   m1_dat_i,
   output logic                            m1_ack,
   output logic                            m1_err,
   output logic                            s_cyc,
   output logic                            s_stb,
   output logic                            s_we,
   output logic [WISHBONE_ADDR_WIDTH-1:0]  s_adr,
   output logic [WISHBONE_BUS_WIDTH-1:0]   s_dat_o,
   output logic [WISHBONE_BUS_WIDTH/8-1:0] s_sel,
   input  logic [WISHBONE_BUS_WIDTH-1:0]   s_dat_i,
   input  logic                            s_ack,
   input  logic                            s_err,
   output logic [1:0]                      grant,
   output logic                            timeout_o
);

   // State encoding doubles as the one-hot grant vector.
   localparam logic [1:0] IDLE    = 2'b00;
   localparam logic [1:0] BUSY_M0 = 2'b01;
   localparam logic [1:0] BUSY_M1 = 2'b10;

   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT_CYCLES);

   logic [1:0]                      state;
   logic [1:0]                      state_nxt;
   logic                            last_grant;   // 1 = m1 was granted last
   logic [CNT_W-1:0]                tmo_cnt;

   logic                            busy;
   logic                            sel_cyc;
   logic                            sel_stb;
   logic                            sel_we;
   logic [WISHBONE_ADDR_WIDTH-1:0]  sel_adr;
   logic [WISHBONE_BUS_WIDTH-1:0]   sel_dat;
   logic [WISHBONE_BUS_WIDTH/8-1:0] sel_sel;
   logic                            timeout_hit;

   assign busy = (state != IDLE);

   always_comb begin
      sel_cyc = 1'b0;
      sel_stb = 1'b0;
      sel_we  = 1'b0;
      sel_adr = '0;
      sel_dat = '0;
      sel_sel = '0;
      if (state == BUSY_M0) begin
         sel_cyc = m0_cyc;
         sel_stb = m0_stb;
         sel_we  = m0_we;
         sel_adr = m0_adr;
         sel_dat = m0_dat_o;
         sel_sel = m0_sel;
      end else if (state == BUSY_M1) begin
         sel_cyc = m1_cyc;
         sel_stb = m1_stb;
         sel_we  = m1_we;
         sel_adr = m1_adr;
         sel_dat = m1_dat_o;
         sel_sel = m1_sel;
      end
   end

   // A slave response in the terminal cycle takes priority over the timeout.
   assign timeout_hit = busy && sel_stb && !s_ack && !s_err && (tmo_cnt == TIMEOUT_TC);

   assign s_cyc   = sel_cyc & ~timeout_hit;
   assign s_stb   = sel_stb & ~timeout_hit;
   assign s_we    = sel_we;
   assign s_adr   = sel_adr;
   assign s_dat_o = sel_dat;
   assign s_sel   = sel_sel;

   // Responses are suppressed while reset is asserted so a transfer cut off
   // by reset never completes or errors towards a master.
   assign m0_dat_i  = (state == BUSY_M0) ? s_dat_i : '0;
   assign m1_dat_i  = (state == BUSY_M1) ? s_dat_i : '0;
   assign m0_ack    = (state == BUSY_M0) && s_ack && !rst_i;
   assign m1_ack    = (state == BUSY_M1) && s_ack && !rst_i;
   assign m0_err    = (state == BUSY_M0) && (s_err || timeout_hit) && !rst_i;
   assign m1_err    = (state == BUSY_M1) && (s_err || timeout_hit) && !rst_i;
   assign timeout_o = timeout_hit && !rst_i;
   assign grant     = state;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (m0_cyc && m1_cyc)
               state_nxt = last_grant ? BUSY_M0 : BUSY_M1;
            else if (m0_cyc)
               state_nxt = BUSY_M0;
            else if (m1_cyc)
               state_nxt = BUSY_M1;
         end
         BUSY_M0, BUSY_M1: begin
            if (!sel_cyc || timeout_hit)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         last_grant <= 1'b1;
      end else begin
         state <= state_nxt;
         if (state == IDLE && state_nxt != IDLE)
            last_grant <= (state_nxt == BUSY_M1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || !busy || timeout_hit || !sel_cyc || !sel_stb || s_ack || s_err)
         tmo_cnt <= '0;
      else
         tmo_cnt <= tmo_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a transaction-level owner/counter model.
module tb_wb_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int TMO = 4;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [AW-1:0] m0_adr, m1_adr, s_adr;
   logic [DW-1:0] m0_dat_o, m1_dat_o, m0_dat_i, m1_dat_i, s_dat_o, s_dat_i;
   logic [SW-1:0] m0_sel, m1_sel, s_sel;
   logic          m0_ack, m0_err, m1_ack, m1_err;
   logic          s_cyc, s_stb, s_we, s_ack, s_err;
   logic [1:0]    grant;
   logic          timeout_o;

   wb_arbiter #(
      .WISHBONE_ADDR_WIDTH(AW),
      .WISHBONE_BUS_WIDTH (DW),
      .TIMEOUT_CYCLES     (TMO)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_adr(m0_adr), .m0_we(m0_we),
      .m0_dat_o(m0_dat_o), .m0_sel(m0_sel), .m0_dat_i(m0_dat_i),
      .m0_ack(m0_ack), .m0_err(m0_err),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_adr(m1_adr), .m1_we(m1_we),
      .m1_dat_o(m1_dat_o), .m1_sel(m1_sel), .m1_dat_i(m1_dat_i),
      .m1_ack(m1_ack), .m1_err(m1_err),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
      .s_dat_o(s_dat_o), .s_sel(s_sel), .s_dat_i(s_dat_i),
      .s_ack(s_ack), .s_err(s_err),
      .grant(grant), .timeout_o(timeout_o)
   );

   always #5 clk_i = ~clk_i;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: owner (-1 none, 0/1 master), last granted master,
   // consecutive stalled-strobe cycles of the current owner.
   int own  = -1;
   int last = 1;
   int cnt  = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called just after a falling edge with inputs already applied: checks all
   // outputs against the model, then advances the model across the rising edge.
   task automatic step();
      logic          n_cyc, n_stb, n_we, to;
      logic [AW-1:0] e_adr;
      logic [DW-1:0] e_dat;
      logic [SW-1:0] e_sel;
      logic [1:0]    e_grant;
      logic [DW+1:0] e_r0, e_r1, resp;
      #1;
      n_cyc = 0; n_stb = 0; n_we = 0; e_adr = '0; e_dat = '0; e_sel = '0; e_grant = 2'b00;
      if (own == 0) begin
         n_cyc = m0_cyc; n_stb = m0_stb; n_we = m0_we;
         e_adr = m0_adr; e_dat = m0_dat_o; e_sel = m0_sel; e_grant = 2'b01;
      end else if (own == 1) begin
         n_cyc = m1_cyc; n_stb = m1_stb; n_we = m1_we;
         e_adr = m1_adr; e_dat = m1_dat_o; e_sel = m1_sel; e_grant = 2'b10;
      end
      to   = (own >= 0) && n_stb && !s_ack && !s_err && (cnt == TMO);
      resp = {s_ack && !rst_i, (s_err || to) && !rst_i, s_dat_i};
      e_r0 = (own == 0) ? resp : '0;
      e_r1 = (own == 1) ? resp : '0;
      chk("grant",   grant, e_grant);
      chk("s_ctl",   {s_cyc, s_stb, s_we}, {n_cyc && !to, n_stb && !to, n_we});
      chk("s_adr",   s_adr, e_adr);
      chk("s_dat",   s_dat_o, e_dat);
      chk("s_sel",   s_sel, e_sel);
      chk("m0_resp", {m0_ack, m0_err, m0_dat_i}, e_r0);
      chk("m1_resp", {m1_ack, m1_err, m1_dat_i}, e_r1);
      chk("timeout", timeout_o, to && !rst_i);
      @(posedge clk_i);
      if (rst_i) begin
         own = -1; last = 1; cnt = 0;
      end else if (own < 0) begin
         cnt = 0;
         if (m0_cyc && m1_cyc) own = (last == 1) ? 0 : 1;
         else if (m0_cyc)      own = 0;
         else if (m1_cyc)      own = 1;
         if (own >= 0) last = own;
      end else if (to || !n_cyc) begin
         own = -1; cnt = 0;
      end else if (n_stb && !s_ack && !s_err) begin
         cnt++;
      end else begin
         cnt = 0;
      end
      @(negedge clk_i);
   endtask

   task automatic clear_inputs();
      m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_o = '0; m0_sel = '0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_o = '0; m1_sel = '0;
      s_dat_i = '0; s_ack = 0; s_err = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_i = 1;
      step();
      rst_i = 0;
      step();
   endtask

   task automatic rand_cycles(input int n, input int ack_pct, input int err_pct);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(99) < 12) m0_cyc = ~m0_cyc;
         if ($urandom_range(99) < 12) m1_cyc = ~m1_cyc;
         m0_stb   = m0_cyc && ($urandom_range(3) != 0);
         m1_stb   = m1_cyc && ($urandom_range(3) != 0);
         m0_we    = $urandom_range(1);
         m1_we    = $urandom_range(1);
         m0_adr   = $urandom;
         m1_adr   = $urandom;
         m0_dat_o = $urandom;
         m1_dat_o = $urandom;
         m0_sel   = SW'($urandom);
         m1_sel   = SW'($urandom);
         s_dat_i  = $urandom;
         s_ack    = ($urandom_range(99) < ack_pct);
         s_err    = ($urandom_range(99) < err_pct);
         rst_i    = ($urandom_range(199) == 0);
         step();
      end
      rst_i = 0;
   endtask

   logic [1:0] exp_order [3];

   initial begin
      exp_order[0] = 2'b01;
      exp_order[1] = 2'b10;
      exp_order[2] = 2'b01;
      clear_inputs();
      rst_i = 1;
      @(negedge clk_i);
      step();
      rst_i = 0;
      chk("reset_grant", grant, 2'b00);
      chk("reset_s_cyc", s_cyc, 1'b0);

      // Single m0 read, slave acks two cycles after the grant.
      do_reset();
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0100_0004;
      step();
      chk("rd_grant", grant, 2'b01);
      step();
      step();
      s_ack = 1; s_dat_i = 32'hDEAD_BEEF;
      #1;
      chk("rd_data", m0_dat_i, 32'hDEAD_BEEF);
      chk("rd_ack",  {m0_ack, m1_ack}, 2'b10);
      step();
      clear_inputs();
      step();

      // Three simultaneous requests alternate m0, m1, m0.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 0;
         step();
         chk("rr_grant", grant, exp_order[k]);
         s_ack = 1;
         step();
         clear_inputs();
         step();
         chk("rr_idle", grant, 2'b00);
      end

      // m1 holds the bus for three strobes while m0 waits.
      do_reset();
      m1_cyc = 1; m1_stb = 1;
      step();
      chk("hold_grant", grant, 2'b10);
      m0_cyc = 1; m0_stb = 1; s_ack = 1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("hold_m0_ack", m0_ack, 1'b0);
         step();
         chk("hold_grant_m1", grant, 2'b10);
      end
      m1_cyc = 0; m1_stb = 0; s_ack = 0;
      step();
      chk("hold_gap", grant, 2'b00);
      step();
      chk("hold_m0_grant", grant, 2'b01);
      clear_inputs();
      step();

      // Stalled slave: error on the fifth stalled cycle.
      do_reset();
      m0_cyc = 1; m0_stb = 1;
      step();
      for (int k = 0; k < TMO; k++) step();
      #1;
      chk("tmo_err", {m0_err, timeout_o, s_cyc}, 3'b110);
      step();
      #1;
      chk("tmo_idle", grant, 2'b00);
      clear_inputs();
      step();

      // Ack lands on the terminal cycle: ack wins.
      do_reset();
      m0_cyc = 1; m0_stb = 1;
      step();
      for (int k = 0; k < TMO; k++) step();
      s_ack = 1;
      #1;
      chk("tmo_ack_wins", {m0_ack, m0_err, timeout_o}, 3'b100);
      step();
      clear_inputs();
      step();

      // Reset during an outstanding m1 strobe.
      do_reset();
      m1_cyc = 1; m1_stb = 1;
      step();
      step();
      rst_i = 1;
      step();
      rst_i = 0;
      #1;
      chk("rst_grant", grant, 2'b00);
      chk("rst_s_cyc", s_cyc, 1'b0);
      m0_cyc = 1; m0_stb = 1;
      step();
      chk("rst_tie_m0", grant, 2'b01);
      clear_inputs();
      step();

      // Randomized traffic with differing slave responsiveness.
      do_reset();
      rand_cycles(1500, 50, 5);
      rand_cycles(1500, 10, 2);
      rand_cycles(1500, 25, 0);
      clear_inputs();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
